// File: rtl/inv_cipher_seq_pkg.sv
// Shared AES inverse-cipher definitions: key-length constants, FSM states
// and GF(2^8) helpers for the inverse round.
package inv_cipher_seq_pkg;

    localparam logic [7:0] KLEN_128 = 8'd16;
    localparam logic [7:0] KLEN_192 = 8'd24;
    localparam logic [7:0] KLEN_256 = 8'd32;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREF,
        S_ARK,
        S_ROUND,
        S_FINAL
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3),
                mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3)};
    endfunction

endpackage

// File: rtl/inv_cipher_seq_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns when mix is set.
module aes_inv_round
    import inv_cipher_seq_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         mix,
    output logic [127:0] result
);

    logic [127:0] ark;

    // byte k = row + 4*col sits at [127-8k -: 8]
    always_comb begin
        ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127-8*(r+4*c) -: 8] =
                    inv_sbox(state[127-8*(r+4*((c-r+4)%4)) -: 8]) ^
                    rk[127-8*(r+4*c) -: 8];
            end
        end
    end

    always_comb begin
        result = ark;
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                result[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
            end
        end
    end

endmodule

// File: rtl/inv_cipher_seq.sv
// Iterative AES inverse cipher: one shared inverse round reused Nr times,
// round keys fetched last-first from a synchronous external store.
module inv_cipher_seq
    import inv_cipher_seq_pkg::*;
#(
    parameter int RK_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       i_klen,
    input  logic [127:0]     i_data,
    output logic             rk_en,
    output logic [RK_AW-1:0] rk_addr,
    input  logic [127:0]     rk_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [127:0]     o_data
);

    fsm_t             st, st_n;
    logic [RK_AW-1:0] nr, nr_n;
    logic [RK_AW-1:0] r, r_n;
    logic [RK_AW-1:0] addr_n;
    logic [RK_AW-1:0] nr_dec;
    logic             klen_ok;
    logic             en_n, done_n, err_n;
    logic [127:0]     sq, sq_n, out_n, rnd;

    aes_inv_round u_round (
        .state  (sq),
        .rk     (rk_data),
        .mix    (st == S_ROUND),
        .result (rnd)
    );

    assign busy = (st != S_IDLE);

    always_comb begin
        klen_ok = 1'b1;
        nr_dec  = RK_AW'(NR_128);
        unique case (1'b1)
            (i_klen == KLEN_128): nr_dec = RK_AW'(NR_128);
            (i_klen == KLEN_192): nr_dec = RK_AW'(NR_192);
            (i_klen == KLEN_256): nr_dec = RK_AW'(NR_256);
            default:              klen_ok = 1'b0;
        endcase
    end

    // the store has one cycle of latency, so the address runs one key ahead
    always_comb begin
        st_n   = st;
        nr_n   = nr;
        r_n    = r;
        sq_n   = sq;
        addr_n = rk_addr;
        en_n   = rk_en;
        out_n  = o_data;
        done_n = 1'b0;
        err_n  = 1'b0;
        case (st)
            S_IDLE: begin
                if (start) begin
                    if (klen_ok) begin
                        sq_n   = i_data;
                        nr_n   = nr_dec;
                        addr_n = nr_dec;
                        en_n   = 1'b1;
                        st_n   = S_PREF;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_PREF: begin
                addr_n = nr - RK_AW'(1);
                st_n   = S_ARK;
            end
            S_ARK: begin
                sq_n   = sq ^ rk_data;
                addr_n = nr - RK_AW'(2);
                r_n    = nr - RK_AW'(1);
                st_n   = S_ROUND;
            end
            S_ROUND: begin
                sq_n   = rnd;
                addr_n = (r > RK_AW'(2)) ? r - RK_AW'(2) : '0;
                if (r == RK_AW'(1)) st_n = S_FINAL;
                else                r_n  = r - RK_AW'(1);
            end
            S_FINAL: begin
                out_n  = rnd;
                done_n = 1'b1;
                en_n   = 1'b0;
                r_n    = '0;
                st_n   = S_IDLE;
            end
            default: st_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= S_IDLE;
            nr      <= '0;
            r       <= '0;
            sq      <= '0;
            rk_en   <= 1'b0;
            rk_addr <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            o_data  <= '0;
        end else begin
            st      <= st_n;
            nr      <= nr_n;
            r       <= r_n;
            sq      <= sq_n;
            rk_en   <= en_n;
            rk_addr <= addr_n;
            done    <= done_n;
            err     <= err_n;
            o_data  <= out_n;
        end
    end

endmodule

// File: tb/tb_inv_cipher_seq.sv
// Scoreboard bench for inv_cipher_seq: a forward-AES model encrypts random
// plaintexts, the DUT must recover them; FIPS-197 vectors are checked too.
module tb_inv_cipher_seq;

    localparam int RK_AW = 4;
    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256    = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       i_klen = 8'd0;
    logic [127:0]     i_data = '0;
    logic [127:0]     rk_data = '0;
    logic             rk_en, busy, done, err;
    logic [RK_AW-1:0] rk_addr;
    logic [127:0]     o_data;

    typedef struct {
        logic [127:0] pt;
        int           at;
    } exp_t;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           cur_nr = 10;
    exp_t         exp_q[$];
    int           err_q[$];
    logic [127:0] last_o = '0;
    logic [7:0]   sbox[256];
    logic [127:0] rom[16];

    inv_cipher_seq #(.RK_AW(RK_AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .i_klen  (i_klen),
        .i_data  (i_data),
        .rk_en   (rk_en),
        .rk_addr (rk_addr),
        .rk_data (rk_data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .o_data  (o_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rk_en) rk_data <= rom[rk_addr];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                      rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int klen);
        int nk, nr;
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rcon;
        nk = klen / 4;
        nr = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rom[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s[16], t[16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rom[0][127-8*k -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = sbox[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                {a0, a1, a2, a3} = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
                if (rd != nr) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = {a0, a1, a2, a3};
                end
            end
            for (int k = 0; k < 16; k++) s[k] ^= rom[rd][127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        int   ec;
        if (!reset) begin
            chk("rk_en_vs_busy", 128'(rk_en), 128'(busy));
            if (rk_en) chk("rk_addr_le_nr", 128'(int'(rk_addr) > cur_nr), 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("o_data", o_data, e.pt);
                    chk("done_cycle", 128'(cyc), 128'(e.at));
                end
                last_o = o_data;
            end else begin
                chk("o_data_hold", o_data, last_o);
            end
            if (err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_err", 1, 0);
                end else begin
                    ec = err_q.pop_front();
                    chk("err_cycle", 128'(cyc), 128'(ec));
                end
            end
        end
    end

    task automatic issue(input logic [127:0] ct, input logic [7:0] klen,
                         input logic [127:0] pt, input int nr);
        exp_t e;
        e.pt = pt;
        e.at = cyc + nr + 3;
        exp_q.push_back(e);
        start = 1'b1;
        i_data = ct;
        i_klen = klen;
        @(posedge clk); #1;
        start = 1'b0;
        i_data = rnd128();
        i_klen = 8'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("done_timeout", 128'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic wait_done_pulse();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        chk("done_pulse_wait", 128'(done), 1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 128'(busy), 0);
        chk({tag, "_rk_en"}, 128'(rk_en), 0);
        chk({tag, "_done"}, 128'(done), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int klen, nr;
        logic [127:0] pt, pt2;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset_err", 128'(err), 0);
        chk("reset_rk_addr", 128'(rk_addr), 0);
        chk("reset_o_data", o_data, 0);
        reset = 1'b0;

        expand(FIPS_KEY, 16);
        cur_nr = 10;
        issue(CT128, 8'd16, FIPS_PT, 10);
        for (int i = 0; i < 12; i++) begin
            chk("rk_addr_seq", 128'(rk_addr), 128'((10 - i > 0) ? 10 - i : 0));
            chk("rk_en_active", 128'(rk_en), 1);
            @(posedge clk); #1;
        end
        wait_done();

        expand(FIPS_KEY, 24);
        cur_nr = 12;
        issue(CT192, 8'd24, FIPS_PT, 12);
        wait_done();

        expand(FIPS_KEY, 32);
        cur_nr = 14;
        issue(CT256, 8'd32, FIPS_PT, 14);
        wait_done();

        err_q.push_back(cyc + 1);
        start = 1'b1;
        i_klen = 8'd20;
        i_data = rnd128();
        @(posedge clk); #1;
        start = 1'b0;
        chk("illegal_err_on", 128'(err), 1);
        chk_quiet("illegal");
        @(posedge clk); #1;
        chk("illegal_err_off", 128'(err), 0);
        chk_quiet("illegal2");

        expand(FIPS_KEY, 16);
        cur_nr = 10;
        issue(CT128, 8'd16, FIPS_PT, 10);
        wait_done();

        issue(CT128, 8'd16, FIPS_PT, 10);
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        i_data = rnd128();
        i_klen = 8'd24;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        pt = rnd128();
        pt2 = rnd128();
        issue(encrypt(pt, 10), 8'd16, pt, 10);
        wait_done_pulse();
        issue(encrypt(pt2, 10), 8'd16, pt2, 10);
        wait_done();

        issue(CT128, 8'd16, FIPS_PT, 10);
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk_quiet("midreset");
        chk("midreset_err", 128'(err), 0);
        chk("midreset_rk_addr", 128'(rk_addr), 0);
        chk("midreset_o_data", o_data, 0);
        last_o = '0;
        reset = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        issue(CT128, 8'd16, FIPS_PT, 10);
        wait_done();

        for (int n = 0; n < 24; n++) begin
            klen = 16 + 8 * int'($urandom_range(0, 2));
            nr = klen / 4 + 6;
            expand({rnd128(), rnd128()}, klen);
            cur_nr = nr;
            pt = rnd128();
            issue(encrypt(pt, nr), 8'(klen), pt, nr);
            wait_done();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        chk("err_q_empty", 128'(err_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
